// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, drives the instruction
// memory address and captures the returned word into the IF/ID register.
// Handles stall, flush, branch redirect and a saturating fetch counter.
module fetch_stage #(
    parameter int unsigned              DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR   = 32'hE1A0_0000,
    parameter int unsigned              COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_Stall,
    input  logic                   i_Flush,
    input  logic                   i_Branch_Taken,
    input  logic [DATA_WIDTH-1:0]  i_Branch_Target,
    output logic [DATA_WIDTH-1:0]  o_Imem_Address,
    input  logic [DATA_WIDTH-1:0]  i_Imem_Instruction,
    output logic [DATA_WIDTH-1:0]  o_PC,
    output logic [DATA_WIDTH-1:0]  o_PC_Plus4,
    output logic [DATA_WIDTH-1:0]  o_Instruction,
    output logic                   o_Valid,
    output logic [COUNT_WIDTH-1:0] o_Fetch_Count
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0]  pc_q,       pc_d;
    logic [DATA_WIDTH-1:0]  if_pc_q,    if_pc_d;
    logic [DATA_WIDTH-1:0]  if_pc4_q,   if_pc4_d;
    logic [DATA_WIDTH-1:0]  if_instr_q, if_instr_d;
    logic                   if_valid_q, if_valid_d;
    logic [COUNT_WIDTH-1:0] count_q,    count_d;

    logic [DATA_WIDTH-1:0]  pc_plus4;

    assign pc_plus4 = pc_q + PC_STEP;

    // Next PC: branch redirect (word aligned) beats stall, else sequential.
    always_comb begin
        pc_d = pc_q;
        if (i_Branch_Taken) begin
            pc_d = {i_Branch_Target[DATA_WIDTH-1:2], 2'b00};
        end else if (!i_Stall) begin
            pc_d = pc_plus4;
        end
    end

    // Next IF/ID contents: bubble on branch/flush, hold on stall, else load.
    always_comb begin
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        count_d    = count_q;
        if (i_Branch_Taken || i_Flush) begin
            // Wrong-path fetch is dropped; the address fields keep their old value.
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end else if (!i_Stall) begin
            if_pc_d    = pc_q;
            if_pc4_d   = pc_plus4;
            if_instr_d = i_Imem_Instruction;
            if_valid_d = 1'b1;
            if (count_q != '1) begin
                count_d = count_q + COUNT_WIDTH'(1);
            end
        end
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            count_q    <= count_d;
        end
    end

    assign o_Imem_Address = pc_q;
    assign o_PC           = if_pc_q;
    assign o_PC_Plus4     = if_pc4_q;
    assign o_Instruction  = if_instr_q;
    assign o_Valid        = if_valid_q;
    assign o_Fetch_Count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a behavioural model pushes the expected IF/ID
// state for every edge into a scoreboard, each scenario pops and compares.
// A second instance with a 2-bit counter shares the stimulus to see saturation.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst, stall, flush, br;
    logic [31:0] tgt;

    logic [31:0] addr, imem, o_pc, o_pc4, o_ins;
    logic        o_valid;
    logic [15:0] cnt;

    logic [31:0] addr2, imem2, o_pc_2, o_pc4_2, o_ins_2;
    logic        o_valid_2;
    logic [1:0]  cnt2;

    // Memory word at address N is N + 0x100.
    assign imem  = addr  + 32'h100;
    assign imem2 = addr2 + 32'h100;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(rst), .i_Stall(stall), .i_Flush(flush),
        .i_Branch_Taken(br), .i_Branch_Target(tgt),
        .o_Imem_Address(addr), .i_Imem_Instruction(imem),
        .o_PC(o_pc), .o_PC_Plus4(o_pc4), .o_Instruction(o_ins),
        .o_Valid(o_valid), .o_Fetch_Count(cnt)
    );

    fetch_stage #(.COUNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(rst), .i_Stall(stall), .i_Flush(flush),
        .i_Branch_Taken(br), .i_Branch_Target(tgt),
        .o_Imem_Address(addr2), .i_Imem_Instruction(imem2),
        .o_PC(o_pc_2), .o_PC_Plus4(o_pc4_2), .o_Instruction(o_ins_2),
        .o_Valid(o_valid_2), .o_Fetch_Count(cnt2)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ins;
        logic        valid;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic [31:0] addr;
    } obs_t;

    typedef struct packed {
        logic        s;
        logic        f;
        logic        b;
        logic        r;
        logic [31:0] t;
    } stim_t;

    obs_t act;
    assign act = {o_pc, o_pc4, o_ins, o_valid, cnt, cnt2, addr};

    obs_t sb[$];

    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_ins;
    logic        m_valid;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;

    int checks = 0;
    int errors = 0;

    // Drive one cycle, advance the model, push its expectation, step the clock.
    task automatic cycle(input stim_t st);
        stall = st.s; flush = st.f; br = st.b; tgt = st.t; rst = st.r;
        if (st.r) begin
            m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_ins = NOP;
            m_valid = 1'b0; m_cnt = 16'h0; m_cnt2 = 2'b00;
        end else begin
            if (st.b || st.f) begin
                m_ins = NOP; m_valid = 1'b0;
            end else if (!st.s) begin
                m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_ins = m_pc + 32'h100;
                m_valid = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
            end
            if (st.b) m_pc = {st.t[31:2], 2'b00};
            else if (!st.s) m_pc = m_pc + 32'd4;
        end
        sb.push_back({m_ifpc, m_ifpc4, m_ins, m_valid, m_cnt, m_cnt2, m_pc});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e;
        cycle('{s:0, f:0, b:0, r:1, t:32'h0});
        e = sb.pop_front();
        checks++;
        if (act !== e) begin
            errors++; $display("FAIL reset_sb got=%h need=%h", act, e);
        end
        checks++;
        if (act !== {32'h0, 32'h0, NOP, 1'b0, 16'h0, 2'b00, 32'h0}) begin
            errors++; $display("FAIL reset_values got=%h", act);
        end
    endtask

    task automatic test_free_run();
        obs_t e;
        for (int i = 0; i < 2; i++) begin
            cycle('{s:0, f:0, b:0, r:0, t:32'h0});
            e = sb.pop_front();
            checks++;
            if (act !== e) begin
                errors++; $display("FAIL free_run_sb[%0d] got=%h need=%h", i, act, e);
            end
            if (i == 0) begin
                checks++;
                if ({o_pc, o_pc4, o_ins, o_valid, addr} !== {32'h0, 32'h4, 32'h100, 1'b1, 32'h4}) begin
                    errors++; $display("FAIL first_fetch pc=%h pc4=%h ins=%h v=%b addr=%h need 0/4/100/1/4",
                                       o_pc, o_pc4, o_ins, o_valid, addr);
                end
            end
        end
        checks++;
        if ({addr, o_pc, o_ins, cnt} !== {32'h8, 32'h4, 32'h104, 16'd2}) begin
            errors++; $display("FAIL free_run_end addr=%h pc=%h ins=%h cnt=%0d need 8/4/104/2",
                               addr, o_pc, o_ins, cnt);
        end
    endtask

    task automatic test_stall();
        obs_t  e;
        stim_t st[3];
        st[0] = '{s:1, f:0, b:0, r:0, t:32'h0};
        st[1] = '{s:1, f:0, b:0, r:0, t:32'h0};
        st[2] = '{s:0, f:0, b:0, r:0, t:32'h0};
        for (int i = 0; i < 3; i++) begin
            cycle(st[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e) begin
                errors++; $display("FAIL stall_sb[%0d] got=%h need=%h", i, act, e);
            end
            if (i < 2) begin
                checks++;
                if ({addr, o_pc, o_ins, cnt} !== {32'h8, 32'h4, 32'h104, 16'd2}) begin
                    errors++; $display("FAIL stall_hold[%0d] addr=%h pc=%h ins=%h cnt=%0d need 8/4/104/2",
                                       i, addr, o_pc, o_ins, cnt);
                end
            end
        end
        checks++;
        if ({o_pc, o_valid, cnt, addr} !== {32'h8, 1'b1, 16'd3, 32'hC}) begin
            errors++; $display("FAIL stall_release pc=%h v=%b cnt=%0d addr=%h need 8/1/3/C",
                               o_pc, o_valid, cnt, addr);
        end
    endtask

    task automatic test_branch_stall();
        obs_t  e;
        stim_t st[2];
        st[0] = '{s:1, f:0, b:1, r:0, t:32'h43};
        st[1] = '{s:0, f:0, b:0, r:0, t:32'h0};
        for (int i = 0; i < 2; i++) begin
            cycle(st[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e) begin
                errors++; $display("FAIL branch_sb[%0d] got=%h need=%h", i, act, e);
            end
            if (i == 0) begin
                checks++;
                if ({addr, o_valid, o_ins, o_pc, cnt} !== {32'h40, 1'b0, NOP, 32'h8, 16'd3}) begin
                    errors++; $display("FAIL branch_bubble addr=%h v=%b ins=%h pc=%h cnt=%0d need 40/0/E1A00000/8/3",
                                       addr, o_valid, o_ins, o_pc, cnt);
                end
            end
        end
        checks++;
        if ({o_pc, o_valid, o_ins, addr} !== {32'h40, 1'b1, 32'h140, 32'h44}) begin
            errors++; $display("FAIL branch_target pc=%h v=%b ins=%h addr=%h need 40/1/140/44",
                               o_pc, o_valid, o_ins, addr);
        end
    endtask

    task automatic test_flush();
        obs_t  e;
        stim_t st[5];
        st[0] = '{s:0, f:0, b:1, r:0, t:32'h10};
        st[1] = '{s:0, f:1, b:0, r:0, t:32'h0};
        st[2] = '{s:0, f:0, b:0, r:0, t:32'h0};
        st[3] = '{s:1, f:1, b:0, r:0, t:32'h0};
        st[4] = '{s:0, f:0, b:0, r:0, t:32'h0};
        for (int i = 0; i < 5; i++) begin
            cycle(st[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e) begin
                errors++; $display("FAIL flush_sb[%0d] got=%h need=%h", i, act, e);
            end
            case (i)
                1: begin
                    checks++;
                    if ({o_valid, o_ins, addr} !== {1'b0, NOP, 32'h14}) begin
                        errors++; $display("FAIL flush_alone v=%b ins=%h addr=%h need 0/E1A00000/14",
                                           o_valid, o_ins, addr);
                    end
                end
                2: begin
                    checks++;
                    if ({o_pc, o_valid, o_ins} !== {32'h14, 1'b1, 32'h114}) begin
                        errors++; $display("FAIL flush_next pc=%h v=%b ins=%h need 14/1/114",
                                           o_pc, o_valid, o_ins);
                    end
                end
                3: begin
                    checks++;
                    if ({o_valid, addr, cnt} !== {1'b0, 32'h18, 16'd5}) begin
                        errors++; $display("FAIL flush_stall v=%b addr=%h cnt=%0d need 0/18/5",
                                           o_valid, addr, cnt);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_wrap();
        obs_t  e;
        stim_t st[3];
        st[0] = '{s:0, f:0, b:1, r:0, t:32'hFFFF_FFFC};
        st[1] = '{s:0, f:0, b:0, r:0, t:32'h0};
        st[2] = '{s:0, f:0, b:0, r:0, t:32'h0};
        for (int i = 0; i < 3; i++) begin
            cycle(st[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e) begin
                errors++; $display("FAIL wrap_sb[%0d] got=%h need=%h", i, act, e);
            end
            if (i == 1) begin
                checks++;
                if ({addr, o_pc, o_pc4, o_ins} !== {32'h0, 32'hFFFF_FFFC, 32'h0, 32'hFC}) begin
                    errors++; $display("FAIL wrap_entry addr=%h pc=%h pc4=%h ins=%h need 0/FFFFFFFC/0/FC",
                                       addr, o_pc, o_pc4, o_ins);
                end
            end
        end
    endtask

    task automatic test_saturation();
        obs_t e;
        for (int i = 0; i < 8; i++) begin
            cycle('{s:(i == 7), f:0, b:0, r:(i == 0), t:32'h0});
            e = sb.pop_front();
            checks++;
            if (act !== e) begin
                errors++; $display("FAIL sat_sb[%0d] got=%h need=%h", i, act, e);
            end
        end
        checks++;
        if ({cnt2, cnt} !== {2'b11, 16'd6}) begin
            errors++; $display("FAIL sat_count cnt2=%0d cnt=%0d need 3/6", cnt2, cnt);
        end
    endtask

    task automatic test_reset_midrun();
        obs_t  e;
        stim_t st[4];
        st[0] = '{s:0, f:0, b:0, r:0, t:32'h0};
        st[1] = '{s:0, f:0, b:0, r:0, t:32'h0};
        st[2] = '{s:1, f:1, b:1, r:1, t:32'h80};
        st[3] = '{s:0, f:0, b:0, r:0, t:32'h0};
        for (int i = 0; i < 4; i++) begin
            cycle(st[i]);
            e = sb.pop_front();
            checks++;
            if (act !== e) begin
                errors++; $display("FAIL midrst_sb[%0d] got=%h need=%h", i, act, e);
            end
            if (i == 2) begin
                checks++;
                if (act !== {32'h0, 32'h0, NOP, 1'b0, 16'h0, 2'b00, 32'h0}) begin
                    errors++; $display("FAIL midrst_values got=%h", act);
                end
            end
        end
        checks++;
        if ({o_pc, o_ins, o_valid, cnt, addr} !== {32'h0, 32'h100, 1'b1, 16'd1, 32'h4}) begin
            errors++; $display("FAIL midrst_restart pc=%h ins=%h v=%b cnt=%0d addr=%h need 0/100/1/1/4",
                               o_pc, o_ins, o_valid, cnt, addr);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; br = 1'b0; tgt = 32'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_branch_stall();
        test_flush();
        test_wrap();
        test_saturation();
        test_reset_midrun();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain left=%0d need 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
